fetch_unit: RTL and testbench

//  Instruction-fetch front end directly upstream of the unified memory's instruction port.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 68 ++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end and its neighbours (decode, memory).
// Default widths, FIFO depth and reset PC live here so every block agrees on them.
package fetch_unit_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory port, redirect request and decode handshake.
// master = fetch unit, slave = the memory/decode/branch side around it.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_bus;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output i_addr, inst, inst_pc, inst_valid,
    input  i_bus, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  i_addr, inst, inst_pc, inst_valid,
    output i_bus, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO holding {pc, word} pairs for the fetch unit.
// Head is shown combinationally (zero when empty); flush empties it in one edge.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // The upstream issue rule reserves a slot for every in-flight read.
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one registered memory read per cycle,
// buffers returned words with their PCs, and flushes everything on a branch redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        inflight_pc;
  logic                     inflight;
  logic [CNT_W-1:0]         count;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+DATA_W-1:0] head;

  // A pop in the same cycle is not credited, so buffered + in-flight never exceeds DEPTH.
  assign issue = !bus.redirect && ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
  assign push  = inflight && !bus.redirect;
  assign pop   = bus.inst_valid && bus.inst_ready && !bus.redirect;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
      fetch_pc    <= fetch_pc + 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_unit_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata ({inflight_pc, bus.i_bus}),
    .head  (head),
    .count (count)
  );

  assign bus.i_addr                = fetch_pc;
  assign bus.inst_valid            = (count != '0);
  assign {bus.inst_pc, bus.inst}   = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: registered memory model plus an expected-instruction
// queue filled as each scenario is set up and drained as decode accepts instructions.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hA000 + a;
  endfunction

  // Registered read: word for the address presented before an edge appears after it.
  always @(posedge clk) bus.i_bus <= mem_word(bus.i_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input logic [AW-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] pc;
      pc = start + AW'(i);
      exp_q.push_back('{pc: pc, word: mem_word(pc)});
    end
  endtask

  task automatic do_reset(input logic ready);
    bus.inst_ready  = ready;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accepts one instruction per cycle against the queue; reports gaps and an exhausted budget.
  task automatic drain(input string name, input int budget, output int first_lat);
    int   cyc;
    bit   started;
    exp_t e;
    cyc       = 0;
    started   = 1'b0;
    first_lat = -1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        e = exp_q.pop_front();
        checks++;
        if (!started) begin
          first_lat = cyc;
          started   = 1'b1;
        end
        if (bus.inst_pc !== e.pc || bus.inst !== e.word) begin
          errors++;
          $display("FAIL %s: got pc=%h inst=%h, want pc=%h inst=%h",
                   name, bus.inst_pc, bus.inst, e.pc, e.word);
        end
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL %s gap: inst_valid=%b at cycle %0d, want pc=%h", name, bus.inst_valid, cyc,
                 exp_q[0].pc);
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d instructions outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_lat(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    rst = 1'b1;
    tick();
    checks += 4;
    if (bus.i_addr !== 16'h0000) begin errors++; $display("FAIL reset i_addr: got %h want 0000", bus.i_addr); end
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.inst !== 16'h0000) begin errors++; $display("FAIL reset inst: got %h want 0000", bus.inst); end
    if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL reset inst_pc: got %h want 0000", bus.inst_pc); end
    rst = 1'b0;
    tick();
    checks += 2;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL first edge inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.i_addr !== 16'h0001) begin errors++; $display("FAIL first edge i_addr: got %h want 0001", bus.i_addr); end
  endtask

  task automatic test_stream();
    int lat;
    expect_stream(16'h0000, 8);
    drain("stream", 20, lat);
    check_lat("stream", lat, 1);
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset(1'b0);
    repeat (8) tick();
    checks += 3;
    if (bus.i_addr !== 16'h0004) begin errors++; $display("FAIL park i_addr: got %h want 0004", bus.i_addr); end
    if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL park inst_valid: got %b want 1", bus.inst_valid); end
    if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL park head pc: got %h want 0000", bus.inst_pc); end
    expect_stream(16'h0000, 10);
    bus.inst_ready = 1'b1;
    drain("backpressure", 30, lat);
  endtask

  task automatic test_redirect_flush();
    int lat;
    do_reset(1'b0);
    repeat (4) tick();
    checks += 2;
    if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL pre-flush inst_valid: got %b want 1", bus.inst_valid); end
    if (bus.i_addr !== 16'h0004) begin errors++; $display("FAIL pre-flush i_addr: got %h want 0004", bus.i_addr); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    checks += 2;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.i_addr !== 16'h0100) begin errors++; $display("FAIL flush i_addr: got %h want 0100", bus.i_addr); end
    expect_stream(16'h0100, 6);
    drain("flush", 20, lat);
    check_lat("flush", lat, 2);
  endtask

  task automatic test_wrap();
    int lat;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    checks++;
    if (bus.i_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap i_addr: got %h want fffe", bus.i_addr); end
    expect_stream(16'hFFFE, 4);
    drain("wrap", 20, lat);
    check_lat("wrap", lat, 2);
  endtask

  task automatic test_back_to_back();
    int lat;
    checks++;
    if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL b2b pre inst_valid: got %b want 1", bus.inst_valid); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0020;
    tick();
    checks++;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL b2b first inst_valid: got %b want 0", bus.inst_valid); end
    bus.redirect_pc = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    checks += 2;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL b2b second inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.i_addr !== 16'h0040) begin errors++; $display("FAIL b2b i_addr: got %h want 0040", bus.i_addr); end
    expect_stream(16'h0040, 4);
    drain("back_to_back", 20, lat);
    check_lat("back_to_back", lat, 2);
  endtask

  task automatic test_mid_reset();
    int lat;
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    checks++;
    if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL mid pre inst_valid: got %b want 1", bus.inst_valid); end
    rst             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0777;
    tick();
    checks += 4;
    if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL mid inst_valid: got %b want 0", bus.inst_valid); end
    if (bus.i_addr !== 16'h0000) begin errors++; $display("FAIL mid i_addr: got %h want 0000", bus.i_addr); end
    if (bus.inst !== 16'h0000) begin errors++; $display("FAIL mid inst: got %h want 0000", bus.inst); end
    if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL mid inst_pc: got %h want 0000", bus.inst_pc); end
    rst            = 1'b0;
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    expect_stream(16'h0000, 6);
    drain("mid_reset", 20, lat);
    check_lat("mid_reset", lat, 2);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
